// File: rtl/pllphase_ctrl_pkg.sv
// Shared types and constants for the PLL phase-divider sequencing controller.
package pllphase_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_READY  = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  // Divider is considered live once this many f_dvd2 edges were seen in the window.
  localparam int MIN_TOGGLES = 2;

  localparam int   DEF_HOLD_CYC   = 4;
  localparam int   DEF_SETTLE_CYC = 16;
  localparam logic DEF_CBIT_RST   = 1'b0;
  localparam int   DEF_CNT_W      = 5;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/pll_toggle_mon.sv
// Liveness monitor: registers f_dvd2 and counts its changes (saturating at 3).
module pll_toggle_mon
  import pllphase_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       clr,
  input  logic       en,
  input  logic       f_dvd2,
  output logic [1:0] tog_cnt
);

  logic       f_dvd2_q_r;
  logic [1:0] tog_cnt_r;
  logic [1:0] tog_cnt_s;

  // next toggle count: clear wins, otherwise count changes while enabled
  always_comb begin
    tog_cnt_s = tog_cnt_r;
    if (clr) begin
      tog_cnt_s = 2'd0;
    end else if (en && (f_dvd2 != f_dvd2_q_r)) begin
      tog_cnt_s = sat_inc2(tog_cnt_r);
    end else begin
      tog_cnt_s = tog_cnt_r;
    end
  end

  // sample register and toggle counter
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      f_dvd2_q_r <= 1'b0;
      tog_cnt_r  <= 2'd0;
    end else begin
      f_dvd2_q_r <= f_dvd2;
      tog_cnt_r  <= tog_cnt_s;
    end
  end

  assign tog_cnt = tog_cnt_r;

endmodule

// File: rtl/pllphase_seq_ctrl.sv
// Sequences divide-mode changes of the PLL phase divider: hold in reset while
// cbit changes, release, then verify f_dvd2 activity before reporting ready.
module pllphase_seq_ctrl
  import pllphase_ctrl_pkg::*;
#(
  parameter int   HOLD_CYC   = DEF_HOLD_CYC,
  parameter int   SETTLE_CYC = DEF_SETTLE_CYC,
  parameter logic CBIT_RST   = DEF_CBIT_RST,
  parameter int   CNT_W      = DEF_CNT_W
)(
  input  logic CLK,
  input  logic RESETB,
  input  logic req,
  input  logic req_cbit,
  input  logic f_dvd2,
  output logic ack,
  output logic sr,
  output logic cbit,
  output logic busy,
  output logic ready,
  output logic fault
);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [1:0]       TOG_MIN     = 2'(MIN_TOGGLES);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             mode_r, mode_s;
  logic             accept_s;
  logic [1:0]       tog_cnt_s;
  logic             mon_clr_s, mon_en_s;

  logic sr_s, busy_s, ready_s, fault_s;
  logic ack_r, sr_r, cbit_r, busy_r, ready_r, fault_r;

  assign mon_clr_s = (state_r == ST_HOLD);
  assign mon_en_s  = (state_r == ST_SETTLE);

  pll_toggle_mon u_toggle_mon (
    .CLK     (CLK),
    .RESETB  (RESETB),
    .clr     (mon_clr_s),
    .en      (mon_en_s),
    .f_dvd2  (f_dvd2),
    .tog_cnt (tog_cnt_s)
  );

  // state, counter and latched mode register
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_r <= ST_HOLD;
      cnt_r   <= CNT_ZERO;
      mode_r  <= CBIT_RST;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
    end
  end

  // next-state, counter and request acceptance
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    mode_s   = mode_r;
    accept_s = 1'b0;
    case (state_r)
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_s = ST_SETTLE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          cnt_s   = CNT_ZERO;
          state_s = (tog_cnt_s >= TOG_MIN) ? ST_READY : ST_FAULT;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_READY, ST_FAULT: begin
        // a request held through HOLD/SETTLE is picked up here
        if (req) begin
          accept_s = 1'b1;
          state_s  = ST_HOLD;
          cnt_s    = CNT_ZERO;
          mode_s   = req_cbit;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_HOLD;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // output decode from the next state so the registered outputs line up with it
  always_comb begin
    sr_s    = 1'b1;
    busy_s  = 1'b1;
    ready_s = 1'b0;
    fault_s = 1'b0;
    case (state_s)
      ST_HOLD: begin
        sr_s   = 1'b1;
        busy_s = 1'b1;
      end
      ST_SETTLE: begin
        sr_s   = 1'b0;
        busy_s = 1'b1;
      end
      ST_READY: begin
        sr_s    = 1'b0;
        busy_s  = 1'b0;
        ready_s = 1'b1;
      end
      ST_FAULT: begin
        sr_s    = 1'b1;
        busy_s  = 1'b0;
        fault_s = 1'b1;
      end
      default: begin
        sr_s   = 1'b1;
        busy_s = 1'b1;
      end
    endcase
  end

  // output registers
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      ack_r   <= 1'b0;
      sr_r    <= 1'b1;
      cbit_r  <= CBIT_RST;
      busy_r  <= 1'b1;
      ready_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      ack_r   <= accept_s;
      sr_r    <= sr_s;
      cbit_r  <= mode_s;
      busy_r  <= busy_s;
      ready_r <= ready_s;
      fault_r <= fault_s;
    end
  end

  assign ack   = ack_r;
  assign sr    = sr_r;
  assign cbit  = cbit_r;
  assign busy  = busy_r;
  assign ready = ready_r;
  assign fault = fault_r;

endmodule

// File: tb/tb_pllphase_seq_ctrl.sv
// Directed self-checking bench for pllphase_seq_ctrl with default parameters.
module tb_pllphase_seq_ctrl;

  logic CLK = 1'b0;
  logic RESETB;
  logic req;
  logic req_cbit;
  logic f_dvd2 = 1'b0;
  logic ack, sr, cbit, busy, ready, fault;

  logic f_toggle;
  logic f_level;

  int n_checks = 0;
  int n_pass   = 0;

  pllphase_seq_ctrl dut (
    .CLK      (CLK),
    .RESETB   (RESETB),
    .req      (req),
    .req_cbit (req_cbit),
    .f_dvd2   (f_dvd2),
    .ack      (ack),
    .sr       (sr),
    .cbit     (cbit),
    .busy     (busy),
    .ready    (ready),
    .fault    (fault)
  );

  always #5 CLK = ~CLK;

  // divider feedback model: toggle every cycle or sit at a chosen level
  always @(negedge CLK) f_dvd2 = f_toggle ? ~f_dvd2 : f_level;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  // expected vector order: {sr, cbit, busy, ready, fault, ack}
  task automatic chk_out(input string tag, input logic [5:0] e);
    check({tag, ".sr"},    sr,    e[5]);
    check({tag, ".cbit"},  cbit,  e[4]);
    check({tag, ".busy"},  busy,  e[3]);
    check({tag, ".ready"}, ready, e[2]);
    check({tag, ".fault"}, fault, e[1]);
    check({tag, ".ack"},   ack,   e[0]);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESETB = 1'b0; req = 1'b0; req_cbit = 1'b0; f_toggle = 1'b1; f_level = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_out("rst", 6'b101000);

    // power-up with a live divider
    @(negedge CLK);
    RESETB = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("pu.cbit", cbit, 1'b0);
      check("pu.ack", ack, 1'b0);
      if (k == 3)  check("pu.sr_hold", sr, 1'b1);
      if (k == 4)  check("pu.sr_fall", sr, 1'b0);
      if (k == 19) check("pu.ready_early", ready, 1'b0);
    end
    chk_out("pu.done", 6'b000100);

    // mode change to cbit=1
    req = 1'b1; req_cbit = 1'b1;
    tick();
    chk_out("mc.acc", 6'b111001);
    req = 1'b0; req_cbit = 1'b0;
    tick();
    check("mc.ack_once", ack, 1'b0);
    tick_n(2);
    check("mc.sr_hold", sr, 1'b1);
    tick();
    check("mc.sr_fall", sr, 1'b0);
    check("mc.cbit", cbit, 1'b1);
    tick_n(15);
    check("mc.ready_early", ready, 1'b0);
    tick();
    chk_out("mc.ready", 6'b010100);

    // dead divider during SETTLE, then retry with live divider
    req = 1'b1; req_cbit = 1'b0; f_toggle = 1'b0; f_level = 1'b0;
    tick();
    chk_out("dd.acc", 6'b101001);
    req = 1'b0;
    tick_n(19);
    chk_out("dd.settle", 6'b001000);
    tick();
    chk_out("dd.fault", 6'b100010);
    tick_n(3);
    chk_out("dd.parked", 6'b100010);
    f_toggle = 1'b1; req = 1'b1; req_cbit = 1'b1;
    tick();
    chk_out("dd.retry", 6'b111001);
    req = 1'b0;
    tick_n(20);
    chk_out("dd.ready", 6'b010100);

    // request raised during SETTLE is held off until READY
    req = 1'b1; req_cbit = 1'b0;
    tick();
    chk_out("rb.acc", 6'b101001);
    req = 1'b0;
    tick_n(6);
    req = 1'b1; req_cbit = 1'b1;
    for (int k = 7; k <= 19; k++) begin
      tick();
      check("rb.no_ack", ack, 1'b0);
      check("rb.cbit", cbit, 1'b0);
    end
    tick();
    chk_out("rb.ready", 6'b000100);
    tick();
    chk_out("rb.acc2", 6'b111001);
    req = 1'b0; req_cbit = 1'b0;

    // reset mid-SETTLE after switching to cbit=1
    tick_n(6);
    chk_out("rs.settle", 6'b011000);
    #2;
    RESETB = 1'b0;
    #1;
    chk_out("rs.async", 6'b101000);
    @(negedge CLK);
    RESETB = 1'b1;
    tick_n(3);
    chk_out("rs.hold", 6'b101000);
    tick();
    chk_out("rs.settle2", 6'b001000);
    tick_n(16);
    chk_out("rs.ready", 6'b000100);

    // boundary: exactly two toggles in the window
    f_toggle = 1'b0; f_level = 1'b0; req = 1'b1; req_cbit = 1'b0;
    tick();
    check("b2.ack", ack, 1'b1);
    req = 1'b0;
    tick_n(7);
    f_level = 1'b1;
    tick_n(3);
    f_level = 1'b0;
    tick_n(10);
    chk_out("b2.ready", 6'b000100);

    // boundary: exactly one toggle in the window
    req = 1'b1;
    tick();
    check("b1.ack", ack, 1'b1);
    req = 1'b0;
    tick_n(7);
    f_level = 1'b1;
    tick_n(13);
    chk_out("b1.fault", 6'b100010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
